// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: walks all K*K kernel positions of one tile from a single start pulse.
// Optional perf_cycles/stall_cycles counters are built when CONV_PERF_CNT_EN is defined.
module conv_seq_ctrl #(
  parameter int unsigned M        = 6,
  parameter int unsigned K        = 3,
  parameter int unsigned STRIDE   = 1,
  parameter int unsigned COL      = 8,
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned ACT_BASE = 0,
  parameter int unsigned WGT_BASE = 1024,
  localparam int unsigned OUT     = (M - K) / STRIDE + 1,
  localparam int unsigned LEN_NIJ = OUT * OUT,
  localparam int unsigned NKIJ    = K * K,
  localparam int unsigned KIJ_W   = (NKIJ > 1) ? $clog2(NKIJ) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              host_cen,
  input  logic              host_wen,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic              l0_full,
  output logic              l0_wr,
  output logic              l0_rd,
  output logic              load,
  output logic              execute,
  input  logic              psum_wr,
  output logic              rchip,
  output logic [KIJ_W-1:0]  kij_idx,
  output logic              busy,
  output logic              done
`ifdef CONV_PERF_CNT_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int unsigned CNT_MAX = (COL > LEN_NIJ) ? COL : LEN_NIJ;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned OUT_W   = (OUT > 1) ? $clog2(OUT) : 1;
  localparam int unsigned K_W     = (K > 1) ? $clog2(K) : 1;

  localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(COL - 1);
  localparam logic [CNT_W-1:0] EXEC_LAST = CNT_W'(LEN_NIJ - 1);
  localparam logic [CNT_W-1:0] PSUM_FULL = CNT_W'(LEN_NIJ);
  localparam logic [OUT_W-1:0] OUT_LAST  = OUT_W'(OUT - 1);
  localparam logic [K_W-1:0]   K_LAST    = K_W'(K - 1);
  localparam logic [KIJ_W-1:0] KIJ_LAST  = KIJ_W'(NKIJ - 1);

  typedef enum logic [2:0] {
    StIdle, StLdWgtL0, StLdWgtPe, StLdActL0, StExec, StDrain, StDone
  } state_e;

  state_e             state_q;
  logic [KIJ_W-1:0]   kij_q;
  logic [K_W-1:0]     ki_q, kj_q;
  logic [CNT_W-1:0]   cnt_q, psum_cnt_q;
  logic [OUT_W-1:0]   ox_q, oy_q;
  logic               cen_q, l0_wr_q, l0_rd_q, load_q, execute_q, busy_q, done_q, rchip_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  wgt_addr, act_addr;

  always_comb begin
    wgt_addr = ADDR_W'(WGT_BASE) + ADDR_W'(kij_q) * ADDR_W'(COL) + ADDR_W'(cnt_q);
    act_addr = ADDR_W'(ACT_BASE)
             + (ADDR_W'(ki_q) + ADDR_W'(oy_q) * ADDR_W'(STRIDE)) * ADDR_W'(M)
             + ADDR_W'(kj_q) + ADDR_W'(ox_q) * ADDR_W'(STRIDE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      kij_q      <= '0;
      ki_q       <= '0;
      kj_q       <= '0;
      cnt_q      <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      psum_cnt_q <= '0;
      cen_q      <= 1'b1;
      addr_q     <= '0;
      l0_wr_q    <= 1'b0;
      l0_rd_q    <= 1'b0;
      load_q     <= 1'b0;
      execute_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rchip_q    <= 1'b0;
    end else begin
      cen_q     <= 1'b1;
      // The L0 write trails the read issue by one cycle to meet the returning SRAM data.
      l0_wr_q   <= ~cen_q & ~abort;
      l0_rd_q   <= 1'b0;
      load_q    <= 1'b0;
      execute_q <= 1'b0;
      done_q    <= 1'b0;
      if ((state_q == StExec || state_q == StDrain) && psum_wr && psum_cnt_q != PSUM_FULL) begin
        psum_cnt_q <= psum_cnt_q + CNT_W'(1);
      end
      if (abort) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              kij_q      <= '0;
              ki_q       <= '0;
              kj_q       <= '0;
              cnt_q      <= '0;
              ox_q       <= '0;
              oy_q       <= '0;
              psum_cnt_q <= '0;
              rchip_q    <= 1'b0;
              busy_q     <= 1'b1;
              state_q    <= StLdWgtL0;
            end
          end
          StLdWgtL0: begin
            if (!l0_full) begin
              cen_q  <= 1'b0;
              addr_q <= wgt_addr;
              if (cnt_q == COL_LAST) begin
                cnt_q   <= '0;
                state_q <= StLdWgtPe;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          StLdWgtPe: begin
            load_q  <= 1'b1;
            l0_rd_q <= 1'b1;
            if (cnt_q == COL_LAST) begin
              cnt_q   <= '0;
              state_q <= StLdActL0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          StLdActL0: begin
            if (!l0_full) begin
              cen_q  <= 1'b0;
              addr_q <= act_addr;
              if (ox_q == OUT_LAST) begin
                ox_q <= '0;
                if (oy_q == OUT_LAST) begin
                  oy_q       <= '0;
                  psum_cnt_q <= '0;
                  state_q    <= StExec;
                end else begin
                  oy_q <= oy_q + OUT_W'(1);
                end
              end else begin
                ox_q <= ox_q + OUT_W'(1);
              end
            end
          end
          StExec: begin
            execute_q <= 1'b1;
            l0_rd_q   <= 1'b1;
            if (cnt_q == EXEC_LAST) begin
              cnt_q   <= '0;
              state_q <= StDrain;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          StDrain: begin
            if (psum_cnt_q == PSUM_FULL) begin
              if (kij_q == KIJ_LAST) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= StDone;
              end else begin
                kij_q   <= kij_q + KIJ_W'(1);
                rchip_q <= ~rchip_q;
                if (kj_q == K_LAST) begin
                  kj_q <= '0;
                  ki_q <= ki_q + K_W'(1);
                end else begin
                  kj_q <= kj_q + K_W'(1);
                end
                state_q <= StLdWgtL0;
              end
            end
          end
          StDone: state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign sram_cen  = (state_q == StIdle) ? host_cen : cen_q;
  assign sram_wen  = (state_q == StIdle) ? host_wen : 1'b1;
  assign sram_addr = (state_q == StIdle) ? host_addr : addr_q;
  assign l0_wr     = l0_wr_q;
  assign l0_rd     = l0_rd_q;
  assign load      = load_q;
  assign execute   = execute_q;
  assign rchip     = rchip_q;
  assign kij_idx   = kij_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef CONV_PERF_CNT_EN
  logic stall_now;
  assign stall_now = ((state_q == StLdWgtL0 || state_q == StLdActL0) && l0_full)
                   || (state_q == StDrain && psum_cnt_q != PSUM_FULL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_cycles  <= '0;
      stall_cycles <= '0;
    end else if (state_q == StIdle && start && !abort) begin
      perf_cycles  <= '0;
      stall_cycles <= '0;
    end else begin
      if (busy_q && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
      if (busy_q && stall_now && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
Parametrised convolution sequencer that walks all K*K kernel positions (kij) of one layer tile from a single start pulse, with no testbench stepping per kij.
For each kij it issues activation/weight SRAM reads into L0, loads the weights into the PE array, streams the activation window with configurable stride, and waits for psum write-back.
It toggles the psum ping-pong bank between kij positions.
It sits between the shared act/wgt SRAM and the corelet, replacing per-kij host control.

Parameters:
M, 6, input feature map width/height (square)
K, 3, kernel width/height (square)
STRIDE, 1, convolution stride (>=1)
COL, 8, PE columns = weight rows loaded per kij
ADDR_W, 11, act/wgt SRAM address width
ACT_BASE, 0, activation base address
WGT_BASE, 1024, weight base address; block for kij is at WGT_BASE + kij*COL
Derived localparams: OUT = (M-K)/STRIDE+1; LEN_NIJ = OUT*OUT; NKIJ = K*K.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse, sampled only in IDLE
abort  in  1  synchronous abort, any state
host_cen  in  1  host SRAM chip enable (active low), passed through in IDLE
host_wen  in  1  host SRAM write enable (active low), passed through in IDLE
host_addr  in  ADDR_W  host SRAM address, passed through in IDLE
sram_cen  out  1  act/wgt SRAM chip enable (active low)
sram_wen  out  1  act/wgt SRAM write enable (active low)
sram_addr  out  ADDR_W  act/wgt SRAM address
l0_full  in  1  L0 can accept at most one more entry
l0_wr  out  1  L0 write
l0_rd  out  1  L0 read
load  out  1  PE weight load
execute  out  1  PE execute
psum_wr  in  1  pulse per psum vector written to the write bank
rchip  out  1  psum bank select
kij_idx  out  ceil(log2(NKIJ))  current kernel position
busy  out  1  high from the cycle after start until done
done  out  1  1-cycle pulse at completion

Behaviour:
- Reset values: state=IDLE; all counters=0; sram_cen=1; sram_wen=1; sram_addr=0; l0_wr, l0_rd, load, execute, busy, done, rchip = 0; kij_idx=0.
- Control outputs are registered. The sram_* outputs are combinational muxes: host_* in IDLE, the internal registered values otherwise. Internal sram_wen is always 1 (read only).
- SRAM read latency is 1 cycle. l0_wr is the internal read-issue strobe delayed by one register stage, so it aligns with returning data.
- States and transitions:
  - IDLE: on start, clear kij, rchip, cnt, ox, oy, psum count; go to LD_WGT_L0. start outside IDLE is ignored.
  - LD_WGT_L0: COL reads at WGT_BASE + kij*COL + cnt, cnt = 0..COL-1; then LD_WGT_PE.
  - LD_WGT_PE: COL cycles with l0_rd=1 and load=1; then LD_ACT_L0.
  - LD_ACT_L0: LEN_NIJ reads at ACT_BASE + (ki + oy*STRIDE)*M + (kj + ox*STRIDE). Here ki = kij/K, kj = kij%K; ox runs fastest, 0..OUT-1. Then EXEC.
  - EXEC: LEN_NIJ cycles with l0_rd=1 and execute=1; then DRAIN.
  - DRAIN: wait until the psum_wr count (counted since entry to EXEC) reaches LEN_NIJ.
    - If kij == NKIJ-1, go to DONE.
    - Otherwise kij++, rchip toggles, and go to LD_WGT_L0.
  - DONE: done=1 for one cycle, busy=0, rchip held; return to IDLE.
- Stall: in the LD_*_L0 states, while l0_full=1, no read is issued (internal cen=1) and counters hold. The delayed l0_wr for a read already in flight still completes.
- psum_wr pulses outside EXEC/DRAIN are ignored. Extra pulses beyond LEN_NIJ saturate the count.
- abort: next state is IDLE, all strobes drop next cycle, busy=0, no done pulse, in-flight l0_wr is suppressed.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronous reset).

Optional Feature:
CONV_PERF_CNT_EN: adds outputs perf_cycles[31:0] and stall_cycles[31:0].
- perf_cycles counts cycles with busy=1.
- stall_cycles counts cycles stalled by l0_full or waiting in DRAIN.
- Both counters clear on start, hold after done, and saturate at all ones.
- Without the macro, neither port nor counter logic exists.

Test Plan:
1. M=6, K=3, STRIDE=1, ideal L0, psum_wr echoed 1 cycle after execute. For kij=0, activation addresses are 0,1,2,3,6,7,8,9,12..15,18..21. For kij=4, first address 7 and last 28. For kij=8, first 14 and last 35. Exactly 9 kij passes; rchip sequence 0,1,0,...,0; one done pulse.
2. Weight addresses for kij=2 are 1040..1047 with l0_wr one cycle later each. load and l0_rd are high for exactly 8 cycles.
3. M=7, K=3, STRIDE=2: OUT=3. kij=0 activation addresses are 0,2,4,14,16,18,28,30,32, then EXEC lasts 9 cycles.
4. Hold l0_full=1 for 5 cycles mid LD_ACT_L0: address sequence is unchanged, the stall is exactly 5 cycles, and no L0 write is lost or duplicated.
5. abort in EXEC of kij=3: next cycle state=IDLE, busy=0, no done. A new start replays from kij=0 with rchip=0.
6. Host writes in IDLE appear on sram_* with the same values. reset_n low mid-LD_WGT_PE clears load/l0_rd asynchronously.
